// File: rtl/hamming_enc_sched.sv
// Two-requester round-robin front end for one shared combinational Hamming(16,11)
// SEC-DED encoder, plus the encoder itself. Codewords use bit positions 16:1.

module hamming16_11_enc (
  input  logic [10:0] d,
  output logic [16:1] cw
);
  logic        p1, p2, p4, p8;
  logic [15:1] body;

  // Each parity bit covers the positions whose index has that bit set.
  assign p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
  assign p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
  assign p4 = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
  assign p8 = ^d[10:4];

  assign body = {d[10:4], p8, d[3:1], p4, d[0], p2, p1};
  assign cw   = {^body, body};
endmodule

module hamming_enc_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [10:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [10:0]      req1_data,
  output logic             req1_ready,
  output logic [10:0]      enc_in,
  input  logic [16:1]      enc_out,
  output logic             cw_valid,
  output logic [16:1]      cw_data,
  output logic             cw_src,
  input  logic             cw_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [10:0]      hold_reg;
  logic             idx_reg;
  logic             last_reg;
  logic             cw_valid_reg;
  logic [16:1]      cw_data_reg;
  logic             cw_src_reg;
  logic [CNT_W-1:0] cnt0_reg, cnt1_reg;
  logic             any_valid;
  logic             win;

  // Requester 1 wins when alone, or in contention when requester 0 was served last.
  assign any_valid = req0_valid | req1_valid;
  assign win       = req1_valid & (~req0_valid | ~last_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_valid) state_next = ENCODE;
      ENCODE:  state_next = HOLD;
      HOLD:    if (cw_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is combinational so a requester is accepted in the same cycle it wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_reg == IDLE && !rst) begin
      req0_ready = req0_valid & ~win;
      req1_ready = win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg     <= '0;
      idx_reg      <= 1'b0;
      last_reg     <= 1'b1;
      cw_valid_reg <= 1'b0;
      cw_data_reg  <= '0;
      cw_src_reg   <= 1'b0;
      cnt0_reg     <= '0;
      cnt1_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            hold_reg <= win ? req1_data : req0_data;
            idx_reg  <= win;
            last_reg <= win;
            if (win) cnt1_reg <= cnt1_reg + CNT_W'(1);
            else     cnt0_reg <= cnt0_reg + CNT_W'(1);
          end
        end
        ENCODE: begin
          cw_data_reg  <= enc_out;
          cw_src_reg   <= idx_reg;
          cw_valid_reg <= 1'b1;
        end
        HOLD: begin
          if (cw_ready) cw_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign enc_in   = hold_reg;
  assign cw_valid = cw_valid_reg;
  assign cw_data  = cw_data_reg;
  assign cw_src   = cw_src_reg;
  assign cnt0     = cnt0_reg;
  assign cnt1     = cnt1_reg;
endmodule
